// File: rtl/mem_bus_responder.sv
// Memory-side line responder: accepts one line request, then bursts BEATS words out of (read) or into (write) an internal array.
// Latency: first beat LATENCY+1 cycles after accept, then one beat per cycle; define MEMRESP_CWF_EN for critical-word-first order.
// Backpressure: none; the initiator ends or aborts with mem_done, and requests arriving while busy are dropped.
module mem_bus_responder #(
    parameter int BUSDATAW       = 32,
    parameter int BUSADDRW       = 32,
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int LATENCY        = 4,
    parameter int BEATS          = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BUSADDRW-1:0] mem_addr,
    input  logic                mem_req,
    input  logic                mem_en,
    input  logic                mem_rd_wr,
    input  logic [BUSDATAW-1:0] mem_wr_data,
    input  logic                mem_done,
    output logic                mem_data_valid,
    output logic [BUSDATAW-1:0] mem_data,
    output logic                resp_busy
);

    localparam int AW = MEM_WORDS_LOG2;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [AW-1:0] OFS_MASK = AW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       word_q, word_d;
    logic                rd_q, rd_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [LW-1:0]       lat_q, lat_d;
    logic                valid_q;
    logic [BUSDATAW-1:0] data_q;
    logic                busy_q;

    logic [BUSDATAW-1:0] mem_q [0:(1<<AW)-1];

    logic                wr_en;
    logic [AW-1:0]       cur_addr;
    logic [AW-1:0]       nxt_addr;
    logic                last_beat;
    logic                unused_addr_bits;

    // Byte-offset bits and bits above the array depth alias away.
    assign unused_addr_bits = ^{mem_addr[BUSADDRW-1:AW+2], mem_addr[1:0]};

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] word,
                                                 input logic [BW-1:0] beat);
        logic [AW-1:0] ofs;
`ifdef MEMRESP_CWF_EN
        ofs = (word + AW'(beat)) & OFS_MASK;
`else
        ofs = AW'(beat) & OFS_MASK;
`endif
        return (word & ~OFS_MASK) | ofs;
    endfunction

    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign cur_addr  = beat_addr(word_q, beat_q);
    assign nxt_addr  = beat_addr(word_d, beat_d);
    assign wr_en     = (state_q == S_BURST) && !rd_q && !reset;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        rd_d    = rd_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req && mem_en) begin
                    word_d  = mem_addr[AW+1:2];
                    rd_d    = mem_rd_wr;
                    beat_d  = '0;
                    lat_d   = '0;
                    state_d = (LATENCY == 0) ? S_BURST : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    state_d = S_IDLE;
                end else if (lat_q == LW'(LATENCY - 1)) begin
                    state_d = S_BURST;
                    beat_d  = '0;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_BURST: begin
                // mem_done on the last beat also lands here, skipping DONE.
                if (mem_done) begin
                    state_d = S_IDLE;
                end else if (last_beat) begin
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            S_DONE: begin
                if (mem_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            rd_q    <= 1'b0;
            beat_q  <= '0;
            lat_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            rd_q    <= rd_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            valid_q <= (state_d == S_BURST);
            busy_q  <= (state_d != S_IDLE);
            data_q  <= ((state_d == S_BURST) && rd_d) ? mem_q[nxt_addr] : '0;
        end
    end

    // Write beat commits at the end of the cycle it is strobed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[cur_addr] <= mem_wr_data;
        end
    end

    assign mem_data_valid = valid_q;
    assign mem_data       = data_q;
    assign resp_busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed table on LATENCY=4 and LATENCY=0 instances, then random traffic against a word-array model.
module tb_mem_bus_responder;

`ifdef MEMRESP_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, mem_req, mem_en, mem_rd_wr, mem_done, sel;
    logic [31:0] mem_addr, mem_wr_data;
    logic        v4, b4, v0, b0;
    logic [31:0] d4, d0;
    logic        mem_data_valid, resp_busy;
    logic [31:0] mem_data;

    always #5 clk = ~clk;

    mem_bus_responder #(.LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr),
        .mem_req(mem_req & ~sel), .mem_en(mem_en & ~sel), .mem_rd_wr(mem_rd_wr),
        .mem_wr_data(mem_wr_data), .mem_done(mem_done & ~sel),
        .mem_data_valid(v4), .mem_data(d4), .resp_busy(b4));

    mem_bus_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr),
        .mem_req(mem_req & sel), .mem_en(mem_en & sel), .mem_rd_wr(mem_rd_wr),
        .mem_wr_data(mem_wr_data), .mem_done(mem_done & sel),
        .mem_data_valid(v0), .mem_data(d0), .resp_busy(b0));

    assign mem_data_valid = sel ? v0 : v4;
    assign mem_data       = sel ? d0 : d4;
    assign resp_busy      = sel ? b0 : b4;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [2][4096];
    bit          known [2][4096];
    int          pool  [2][$];

    typedef struct {
        bit              sel;
        logic [31:0]     addr;
        bit              rd;
        logic [3:0][31:0] wd;
        logic [3:0][31:0] exp;
        logic [3:0]      chk;
        int              done_beat;
        int              rst_beat;
        int              abort_wait;
        bit              pulse;
        int              done_delay;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr, input int k);
        int idx  = int'((addr >> 2) % 4096);
        int base = idx - idx % 4;
        int off  = CWF ? (idx % 4 + k) % 4 : k;
        return base + off;
    endfunction

    function automatic logic [3:0][31:0] line4(input logic [31:0] a, b, c, d);
        logic [3:0][31:0] v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    // One transaction, starting and ending at a negedge with the responder idle.
    task automatic do_txn(input logic [31:0] addr, input bit rd, input logic [3:0][31:0] wd,
                          input logic [3:0][31:0] exp, input logic [3:0] chk,
                          input int done_beat, input int rst_beat, input int abort_wait,
                          input bit pulse, input int done_delay);
        int lat = sel ? 0 : 4;
        int s   = sel ? 1 : 0;
        bit stop = 1'b0;
        check("idle_busy", 32'(resp_busy), 32'd0);
        mem_addr = addr; mem_rd_wr = rd; mem_req = 1'b1; mem_en = 1'b1;
        @(negedge clk);
        mem_req = 1'b0; mem_en = 1'b0;
        for (int c = 1; c <= lat && !stop; c++) begin
            check("wait_valid", 32'(mem_data_valid), 32'd0);
            check("wait_busy", 32'(resp_busy), 32'd1);
            if (c == abort_wait) begin mem_done = 1'b1; stop = 1'b1; end
            @(negedge clk);
            mem_done = 1'b0;
        end
        if (stop) begin
            check("abort_wait_valid", 32'(mem_data_valid), 32'd0);
            check("abort_wait_busy", 32'(resp_busy), 32'd0);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            check("beat_valid", 32'(mem_data_valid), 32'd1);
            check("beat_busy", 32'(resp_busy), 32'd1);
            if (rd && chk[k]) check("beat_data", mem_data, exp[k]);
            if (!rd) mem_wr_data = wd[k];
            if (pulse && k == 1) begin mem_req = 1'b1; mem_en = 1'b1; mem_addr = addr ^ 32'h40; end
            if (k == rst_beat) reset = 1'b1;
            else if (!rd) begin
                model[s][word_of(addr, k)] = wd[k];
                known[s][word_of(addr, k)] = 1'b1;
            end
            if (k == done_beat) mem_done = 1'b1;
            stop = (k == rst_beat) || (k == done_beat);
            @(negedge clk);
            mem_req = 1'b0; mem_en = 1'b0; mem_done = 1'b0; reset = 1'b0;
            if (stop) begin
                check("stop_valid", 32'(mem_data_valid), 32'd0);
                check("stop_busy", 32'(resp_busy), 32'd0);
                if (k == rst_beat) check("reset_data", mem_data, 32'd0);
                return;
            end
        end
        for (int d = 0; d <= done_delay; d++) begin
            check("done_valid", 32'(mem_data_valid), 32'd0);
            check("done_busy", 32'(resp_busy), 32'd1);
            if (d == done_delay) mem_done = 1'b1;
            @(negedge clk);
            mem_done = 1'b0;
        end
        check("end_busy", 32'(resp_busy), 32'd0);
        check("end_valid", 32'(mem_data_valid), 32'd0);
        if (!rd) pool[s].push_back(word_of(addr, 0) - word_of(addr, 0) % 4);
    endtask

    function automatic vec_t mk(input bit s, input logic [31:0] a, input bit rd,
                                input logic [3:0][31:0] d, input logic [3:0] chk,
                                input int db, input int rb, input int aw, input bit p, input int dd);
        vec_t v;
        v.sel = s; v.addr = a; v.rd = rd; v.wd = d; v.exp = d; v.chk = chk;
        v.done_beat = db; v.rst_beat = rb; v.abort_wait = aw; v.pulse = p; v.done_delay = dd;
        return v;
    endfunction

    initial begin
        logic [3:0][31:0] la, lb, lc, ld, le;
        la = line4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        lb = line4(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        lc = line4(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        ld = line4(32'hD0, 32'hD1, 32'hD2, 32'hD3);
        le = line4(32'hE0, 32'hE1, 32'hE2, 32'hE3);
        tbl[0]  = mk(0, 32'h100, 0, la, 4'hF, -1, -1, -1, 0, 1);
        tbl[1]  = mk(0, 32'h100, 1, la, 4'hF, -1, -1, -1, 0, 0);
        tbl[2]  = mk(0, 32'h200, 0, line4(32'h11, 32'h22, 32'h33, 32'h44), 4'hF, -1, -1, -1, 0, 2);
        tbl[3]  = mk(0, 32'h200, 1, line4(32'h11, 32'h22, 32'h33, 32'h44), 4'hF, -1, -1, -1, 0, 0);
        tbl[4]  = mk(0, 32'h108, 1, CWF ? line4(32'hA2, 32'hA3, 32'hA0, 32'hA1) : la, 4'hF, -1, -1, -1, 0, 1);
        tbl[5]  = mk(0, 32'h100, 1, la, 4'h3, 1, -1, -1, 0, 0);
        tbl[6]  = mk(0, 32'h200, 1, line4(32'h11, 32'h22, 32'h33, 32'h44), 4'hF, -1, -1, -1, 1, 0);
        tbl[7]  = mk(0, 32'h104, 1, CWF ? line4(32'hA1, 32'hA2, 32'hA3, 32'hA0) : la, 4'hF, 3, -1, -1, 0, 0);
        tbl[8]  = mk(0, 32'h300, 0, lb, 4'hF, -1, -1, -1, 0, 0);
        tbl[9]  = mk(0, 32'h300, 0, lc, 4'hF, -1, 2, -1, 0, 0);
        tbl[10] = mk(0, 32'h300, 1, line4(32'hC0, 32'hC1, 32'hB2, 32'hB3), 4'hF, -1, -1, -1, 0, 0);
        tbl[11] = mk(0, 32'h200, 1, la, 4'h0, -1, -1, 2, 0, 0);
        tbl[12] = mk(0, 32'h10200, 0, ld, 4'hF, 1, -1, -1, 0, 0);
        tbl[13] = mk(0, 32'h200, 1, line4(32'hD0, 32'hD1, 32'h33, 32'h44), 4'hF, -1, -1, -1, 0, 0);
        tbl[14] = mk(1, 32'h100, 0, le, 4'hF, -1, -1, -1, 0, 0);
        tbl[15] = mk(1, 32'h10C, 1, CWF ? line4(32'hE3, 32'hE0, 32'hE1, 32'hE2) : le, 4'hF, -1, -1, -1, 0, 1);
        tbl[16] = mk(1, 32'h100, 1, le, 4'hF, -1, -1, -1, 1, 0);
        tbl[17] = mk(1, 32'h100, 1, le, 4'h1, 0, -1, -1, 0, 0);

        reset = 1'b1; mem_req = 1'b0; mem_en = 1'b0; mem_rd_wr = 1'b0; mem_done = 1'b0;
        mem_addr = '0; mem_wr_data = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_valid", 32'(mem_data_valid), 32'd0);
            check("rst_data", mem_data, 32'd0);
            check("rst_busy", 32'(resp_busy), 32'd0);
        end
        sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Request without mem_en must be ignored.
        mem_req = 1'b1; mem_en = 1'b0; mem_rd_wr = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        check("noen_busy", 32'(resp_busy), 32'd0);
        @(negedge clk);
        check("noen_busy2", 32'(resp_busy), 32'd0);

        for (int i = 0; i < 18; i++) begin
            sel = tbl[i].sel;
            do_txn(tbl[i].addr, tbl[i].rd, tbl[i].wd, tbl[i].exp, tbl[i].chk,
                   tbl[i].done_beat, tbl[i].rst_beat, tbl[i].abort_wait, tbl[i].pulse, tbl[i].done_delay);
            @(negedge clk);
        end

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            for (int n = 0; n < 150; n++) begin
                logic [31:0]      a;
                logic [3:0][31:0] wd, ex;
                logic [3:0]       ck;
                bit               rd;
                int               db, rb, aw, dd, mode;
                bit               p;
                rd = (pool[s].size() > 0) && ($urandom_range(0, 1) == 1);
                if (rd) begin
                    int b = pool[s][$urandom_range(0, pool[s].size() - 1)];
                    a = ($urandom & 32'hFFFF_C000) | (32'(b) << 2) | 32'($urandom_range(0, 15));
                end else begin
                    a = $urandom;
                end
                for (int k = 0; k < 4; k++) begin
                    wd[k] = $urandom;
                    ex[k] = model[s][word_of(a, k)];
                    ck[k] = known[s][word_of(a, k)];
                end
                db = -1; rb = -1; aw = -1; p = 1'b0;
                dd = $urandom_range(0, 3);
                mode = $urandom_range(0, 9);
                if (mode == 0) db = $urandom_range(0, 3);
                else if (mode == 1 && s == 0) aw = $urandom_range(1, 4);
                else if (mode == 2 && !rd) rb = $urandom_range(0, 3);
                else if (mode == 3) p = 1'b1;
                do_txn(a, rd, wd, ex, ck, db, rb, aw, p, dd);
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
